// File: rtl/clk_rate_checker.sv
// Clock-rate window checker: samples an upstream rate count on a fixed interval,
// classifies it against [rate_min, rate_max] and tracks lock/fault with statistics.
module clk_rate_checker #(
    parameter int COUNTER_WIDTH   = 32,
    parameter int SAMPLE_INTERVAL = 100000000,
    parameter int LOCK_COUNT      = 3,
    parameter int UNLOCK_COUNT    = 2
) (
    input  logic                     clk_ref,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] value,
    input  logic [COUNTER_WIDTH-1:0] rate_min,
    input  logic [COUNTER_WIDTH-1:0] rate_max,
    input  logic                     sticky_clear,
    output logic                     sample_strobe,
    output logic [COUNTER_WIDTH-1:0] last_value,
    output logic [1:0]               state,
    output logic                     rate_ok,
    output logic                     sticky_fault,
    output logic [15:0]              fault_count,
    output logic [COUNTER_WIDTH-1:0] min_seen,
    output logic [COUNTER_WIDTH-1:0] max_seen
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_LOCKED  = 2'b01,
        ST_FAULT   = 2'b10
    } state_t;

    localparam int TIMER_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_INTERVAL - 1);

    localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] UNLOCK_RUN = RUN_W'(UNLOCK_COUNT);

    localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = {COUNTER_WIDTH{1'b1}};

    logic [TIMER_W-1:0]       timer_reg;
    logic [TIMER_W-1:0]       timer_next;
    logic                     capture;

    logic                     strobe_reg;
    logic [COUNTER_WIDTH-1:0] last_value_reg;

    state_t                   state_reg;
    state_t                   state_next;
    logic [RUN_W-1:0]         good_run_reg;
    logic [RUN_W-1:0]         good_run_next;
    logic [RUN_W-1:0]         bad_run_reg;
    logic [RUN_W-1:0]         bad_run_next;
    logic [RUN_W-1:0]         good_run_inc;
    logic [RUN_W-1:0]         bad_run_inc;
    logic                     fault_entry;

    logic                     sample_invalid;
    logic                     sample_in;
    logic                     sample_valid;

    logic                     sticky_reg;
    logic                     sticky_next;
    logic [15:0]              fault_count_reg;
    logic [15:0]              fault_count_next;
    logic [COUNTER_WIDTH-1:0] min_reg;
    logic [COUNTER_WIDTH-1:0] min_next;
    logic [COUNTER_WIDTH-1:0] max_reg;
    logic [COUNTER_WIDTH-1:0] max_next;

    // Interval timer: free-runs while enabled, parked at zero otherwise.
    assign capture = enable && (timer_reg == TIMER_LAST);

    always_comb begin
        timer_next = timer_reg;
        if (!enable || (timer_reg == TIMER_LAST)) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + TIMER_W'(1);
        end
    end

    // An inverted window (rate_min > rate_max) never satisfies both bounds.
    assign sample_invalid = (value == ALL_ONES);
    assign sample_in      = !sample_invalid && (value >= rate_min) && (value <= rate_max);
    assign sample_valid   = capture && !sample_invalid;

    assign good_run_inc = (good_run_reg >= LOCK_RUN)   ? LOCK_RUN   : good_run_reg + RUN_W'(1);
    assign bad_run_inc  = (bad_run_reg  >= UNLOCK_RUN) ? UNLOCK_RUN : bad_run_reg  + RUN_W'(1);

    always_comb begin
        state_next    = state_reg;
        good_run_next = good_run_reg;
        bad_run_next  = bad_run_reg;
        fault_entry   = 1'b0;

        if (!enable) begin
            state_next    = ST_UNKNOWN;
            good_run_next = '0;
            bad_run_next  = '0;
        end else if (capture) begin
            if (sample_invalid) begin
                state_next    = ST_UNKNOWN;
                good_run_next = '0;
                bad_run_next  = '0;
            end else begin
                if (sample_in) begin
                    good_run_next = good_run_inc;
                    bad_run_next  = '0;
                end else begin
                    good_run_next = '0;
                    bad_run_next  = bad_run_inc;
                end

                unique case (state_reg)
                    ST_UNKNOWN: begin
                        if (good_run_next == LOCK_RUN) begin
                            state_next = ST_LOCKED;
                        end else if (bad_run_next == UNLOCK_RUN) begin
                            state_next = ST_FAULT;
                        end
                    end
                    ST_LOCKED: begin
                        if (bad_run_next == UNLOCK_RUN) begin
                            state_next = ST_FAULT;
                        end
                    end
                    ST_FAULT: begin
                        if (good_run_next == LOCK_RUN) begin
                            state_next = ST_LOCKED;
                        end
                    end
                    default: begin
                        state_next = ST_UNKNOWN;
                    end
                endcase

                if (state_next != state_reg) begin
                    good_run_next = '0;
                    bad_run_next  = '0;
                end
                fault_entry = (state_next == ST_FAULT) && (state_reg != ST_FAULT);
            end
        end
    end

    // Clear is applied first so a coincident fault entry or valid sample lands on top of it.
    always_comb begin
        sticky_next      = sticky_reg;
        fault_count_next = fault_count_reg;
        min_next         = min_reg;
        max_next         = max_reg;

        if (sticky_clear) begin
            sticky_next      = 1'b0;
            fault_count_next = '0;
            min_next         = ALL_ONES;
            max_next         = '0;
        end

        if (fault_entry) begin
            sticky_next = 1'b1;
            if (fault_count_next != 16'hFFFF) begin
                fault_count_next = fault_count_next + 16'd1;
            end
        end

        if (sample_valid) begin
            if (value < min_next) begin
                min_next = value;
            end
            if (value > max_next) begin
                max_next = value;
            end
        end
    end

    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg       <= '0;
            strobe_reg      <= 1'b0;
            last_value_reg  <= ALL_ONES;
            state_reg       <= ST_UNKNOWN;
            good_run_reg    <= '0;
            bad_run_reg     <= '0;
            sticky_reg      <= 1'b0;
            fault_count_reg <= '0;
            min_reg         <= ALL_ONES;
            max_reg         <= '0;
        end else begin
            timer_reg       <= timer_next;
            strobe_reg      <= capture;
            if (capture) begin
                last_value_reg <= value;
            end
            state_reg       <= state_next;
            good_run_reg    <= good_run_next;
            bad_run_reg     <= bad_run_next;
            sticky_reg      <= sticky_next;
            fault_count_reg <= fault_count_next;
            min_reg         <= min_next;
            max_reg         <= max_next;
        end
    end

    assign sample_strobe = strobe_reg;
    assign last_value    = last_value_reg;
    assign state         = state_reg;
    assign rate_ok       = (state_reg == ST_LOCKED);
    assign sticky_fault  = sticky_reg;
    assign fault_count   = fault_count_reg;
    assign min_seen      = min_reg;
    assign max_seen      = max_reg;

endmodule

// File: tb/tb_clk_rate_checker.sv
// Bench for clk_rate_checker: directed vector table, corner sequences, and a
// randomized run compared against a per-sample behavioural model.
module tb_clk_rate_checker;

    localparam int CW = 16;
    localparam int SI = 10;
    localparam int LC = 3;
    localparam int UC = 2;
    localparam logic [CW-1:0] ONES = '1;

    logic          clk_ref = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] value;
    logic [CW-1:0] rate_min;
    logic [CW-1:0] rate_max;
    logic          sticky_clear;
    logic          sample_strobe;
    logic [CW-1:0] last_value;
    logic [1:0]    state;
    logic          rate_ok;
    logic          sticky_fault;
    logic [15:0]   fault_count;
    logic [CW-1:0] min_seen;
    logic [CW-1:0] max_seen;

    always #5 clk_ref = ~clk_ref;

    clk_rate_checker #(
        .COUNTER_WIDTH  (CW),
        .SAMPLE_INTERVAL(SI),
        .LOCK_COUNT     (LC),
        .UNLOCK_COUNT   (UC)
    ) dut (
        .clk_ref      (clk_ref),
        .reset_n      (reset_n),
        .enable       (enable),
        .value        (value),
        .rate_min     (rate_min),
        .rate_max     (rate_max),
        .sticky_clear (sticky_clear),
        .sample_strobe(sample_strobe),
        .last_value   (last_value),
        .state        (state),
        .rate_ok      (rate_ok),
        .sticky_fault (sticky_fault),
        .fault_count  (fault_count),
        .min_seen     (min_seen),
        .max_seen     (max_seen)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a count of consecutive enabled edges picks out the sample
    // edges; a history of sample classes since the last state change decides lock/fault.
    int            m_run;
    int            hist[$];
    logic [1:0]    m_state;
    logic          m_strobe;
    logic          m_sticky;
    logic [CW-1:0] m_last;
    logic [CW-1:0] m_min;
    logic [CW-1:0] m_max;
    logic [15:0]   m_fc;

    typedef struct packed {
        logic [CW-1:0] v;
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic          clr;
        logic [1:0]    st;
        logic          sf;
        logic [15:0]   fc;
        logic [CW-1:0] mn;
        logic [CW-1:0] mx;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input int v, input int lo, input int hi, input int clr,
                                input int st, input int sf, input int fc, input int mn,
                                input int mx);
        vec_t r;
        r.v   = CW'(v);
        r.lo  = CW'(lo);
        r.hi  = CW'(hi);
        r.clr = 1'(clr);
        r.st  = 2'(st);
        r.sf  = 1'(sf);
        r.fc  = 16'(fc);
        r.mn  = CW'(mn);
        r.mx  = CW'(mx);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // 0 = invalid, 1 = in window, 2 = out of window
    function automatic int classify(input logic [CW-1:0] v, input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
        if (v == ONES) return 0;
        if (v >= lo && v <= hi) return 1;
        return 2;
    endfunction

    function automatic int trailing(input int c);
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != c) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_run    = 0;
        hist.delete();
        m_state  = 2'b00;
        m_strobe = 1'b0;
        m_sticky = 1'b0;
        m_last   = ONES;
        m_min    = ONES;
        m_max    = '0;
        m_fc     = '0;
    endtask

    task automatic model_edge();
        int         c = -1;
        logic       fe = 1'b0;
        logic [1:0] ns;
        m_strobe = 1'b0;
        if (!enable) begin
            m_run   = 0;
            m_state = 2'b00;
            hist.delete();
        end else begin
            m_run++;
            if (m_run % SI == 0) begin
                m_strobe = 1'b1;
                m_last   = value;
                c        = classify(value, rate_min, rate_max);
                if (c == 0) begin
                    m_state = 2'b00;
                    hist.delete();
                end else begin
                    hist.push_back(c);
                    if (hist.size() > 16) void'(hist.pop_front());
                    ns = m_state;
                    if (m_state != 2'b01 && trailing(1) >= LC) ns = 2'b01;
                    if (m_state != 2'b10 && trailing(2) >= UC) ns = 2'b10;
                    if (ns != m_state) hist.delete();
                    fe      = (ns == 2'b10) && (m_state != 2'b10);
                    m_state = ns;
                end
            end
        end
        if (sticky_clear) begin
            m_sticky = 1'b0;
            m_fc     = '0;
            m_min    = ONES;
            m_max    = '0;
        end
        if (fe) begin
            m_sticky = 1'b1;
            if (m_fc != 16'hFFFF) m_fc++;
        end
        if (c > 0) begin
            if (value < m_min) m_min = value;
            if (value > m_max) m_max = value;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".strobe"}, 32'(sample_strobe), 32'(m_strobe));
        chk({tag, ".last_value"}, 32'(last_value), 32'(m_last));
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".rate_ok"}, 32'(rate_ok), 32'(m_state == 2'b01));
        chk({tag, ".sticky"}, 32'(sticky_fault), 32'(m_sticky));
        chk({tag, ".fault_count"}, 32'(fault_count), 32'(m_fc));
        chk({tag, ".min_seen"}, 32'(min_seen), 32'(m_min));
        chk({tag, ".max_seen"}, 32'(max_seen), 32'(m_max));
    endtask

    task automatic tick(input string tag);
        @(posedge clk_ref);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".strobe0"}, 32'(sample_strobe), 32'd0);
        chk({tag, ".last1s"}, 32'(last_value), 32'(ONES));
        chk({tag, ".state0"}, 32'(state), 32'd0);
        chk({tag, ".ok0"}, 32'(rate_ok), 32'd0);
        chk({tag, ".sticky0"}, 32'(sticky_fault), 32'd0);
        chk({tag, ".fc0"}, 32'(fault_count), 32'd0);
        chk({tag, ".min1s"}, 32'(min_seen), 32'(ONES));
        chk({tag, ".max0"}, 32'(max_seen), 32'd0);
    endtask

    initial begin
        int strobes;
        int first_at;

        tbl[0]  = mk(100,   95, 105, 0, 0, 0, 0, 100,   100);
        tbl[1]  = mk(100,   95, 105, 0, 0, 0, 0, 100,   100);
        tbl[2]  = mk(100,   95, 105, 0, 1, 0, 0, 100,   100);
        tbl[3]  = mk(90,    95, 105, 0, 1, 0, 0, 90,    100);
        tbl[4]  = mk(100,   95, 105, 0, 1, 0, 0, 90,    100);
        tbl[5]  = mk(90,    95, 105, 0, 1, 0, 0, 90,    100);
        tbl[6]  = mk(90,    95, 105, 0, 2, 1, 1, 90,    100);
        tbl[7]  = mk(100,   95, 105, 0, 2, 1, 1, 90,    100);
        tbl[8]  = mk(100,   95, 105, 0, 2, 1, 1, 90,    100);
        tbl[9]  = mk(100,   95, 105, 0, 1, 1, 1, 90,    100);
        tbl[10] = mk(65535, 95, 105, 0, 0, 1, 1, 90,    100);
        tbl[11] = mk(100,   95, 105, 0, 0, 1, 1, 90,    100);
        tbl[12] = mk(200,   95, 105, 0, 0, 1, 1, 90,    200);
        tbl[13] = mk(200,   95, 105, 1, 2, 1, 1, 200,   200);
        tbl[14] = mk(65535, 95, 105, 1, 0, 0, 0, 65535, 0);
        tbl[15] = mk(105,  110, 100, 0, 0, 0, 0, 105,   105);
        tbl[16] = mk(105,  110, 100, 0, 2, 1, 1, 105,   105);
        tbl[17] = mk(105,  110, 100, 0, 2, 1, 1, 105,   105);

        reset_n      = 1'b0;
        enable       = 1'b1;
        value        = ONES;
        rate_min     = CW'(95);
        rate_max     = CW'(105);
        sticky_clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_ref);
        #1;
        check_reset_values("por");
        reset_n = 1'b1;

        // Directed vectors: each record spans one sample interval; clear pulses on the sample edge.
        for (int r = 0; r < 18; r++) begin
            value    = tbl[r].v;
            rate_min = tbl[r].lo;
            rate_max = tbl[r].hi;
            for (int k = 0; k < SI; k++) begin
                sticky_clear = (k == SI - 1) ? tbl[r].clr : 1'b0;
                tick("vec");
            end
            sticky_clear = 1'b0;
            chk("vec.strobe", 32'(sample_strobe), 32'd1);
            chk("vec.last", 32'(last_value), 32'(tbl[r].v));
            chk("vec.state", 32'(state), 32'(tbl[r].st));
            chk("vec.rate_ok", 32'(rate_ok), 32'(tbl[r].st == 2'b01));
            chk("vec.sticky", 32'(sticky_fault), 32'(tbl[r].sf));
            chk("vec.fault_count", 32'(fault_count), 32'(tbl[r].fc));
            chk("vec.min", 32'(min_seen), 32'(tbl[r].mn));
            chk("vec.max", 32'(max_seen), 32'(tbl[r].mx));
            $display("vec %0d: value=%0d window=[%0d,%0d] clr=%0b -> state=%0b sticky=%0b faults=%0d min=%0d max=%0d",
                     r, value, rate_min, rate_max, tbl[r].clr, state, sticky_fault, fault_count,
                     min_seen, max_seen);
        end

        // Disable while FAULT: state drops to UNKNOWN, no strobes, statistics hold.
        rate_min = CW'(95);
        rate_max = CW'(105);
        value    = CW'(100);
        enable   = 1'b0;
        strobes  = 0;
        for (int k = 0; k < 25; k++) begin
            tick("dis");
            if (k == 0) chk("dis.state_now", 32'(state), 32'd0);
            if (sample_strobe) strobes++;
        end
        chk("dis.strobes", 32'(strobes), 32'd0);
        chk("dis.fault_count_held", 32'(fault_count), 32'd1);
        chk("dis.sticky_held", 32'(sticky_fault), 32'd1);
        chk("dis.last_held", 32'(last_value), 32'd105);
        $display("disable: strobes=%0d state=%0b faults=%0d", strobes, state, fault_count);

        enable   = 1'b1;
        first_at = 0;
        for (int n = 1; n <= 20; n++) begin
            tick("reen");
            if (sample_strobe) begin
                first_at = n;
                break;
            end
        end
        chk("reen.latency", 32'(first_at), 32'(SI));
        $display("re-enable: first strobe after %0d edges", first_at);

        // Reset mid-interval: pending sample abandoned, restart counts from release.
        repeat (5) tick("pre_rst");
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        check_all("async_rst");
        tick("in_rst");
        tick("in_rst");
        reset_n  = 1'b1;
        first_at = 0;
        for (int n = 1; n <= 25; n++) begin
            tick("post_rst");
            if (sample_strobe) begin
                first_at = n;
                break;
            end
        end
        chk("post_rst.latency", 32'(first_at), 32'(SI));
        $display("reset release: first strobe after %0d edges", first_at);

        // Randomized run against the model.
        for (int it = 0; it < 3000; it++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 80)      value = CW'($urandom_range(93, 107));
            else if (sel < 90) value = CW'($urandom_range(60, 140));
            else if (sel < 95) value = ONES;
            else               value = CW'($urandom);
            if (enable) begin
                if ($urandom_range(0, 149) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 4) == 0) enable = 1'b1;
            end
            if ($urandom_range(0, 399) == 0) begin
                rate_min = CW'($urandom_range(90, 110));
                rate_max = CW'($urandom_range(90, 110));
            end
            sticky_clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
                tick("rnd_rst");
                reset_n = 1'b1;
            end
            tick("rnd");
            if (sample_strobe) begin
                $display("sample t=%0t value=%0d window=[%0d,%0d] state=%0b sticky=%0b faults=%0d",
                         $time, last_value, rate_min, rate_max, state, sticky_fault, fault_count);
            end
        end
        sticky_clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
